// File: rtl/m68k_bus_arbiter_if.sv
// Handshake and bus-ownership signals between the Pi-side bus state machine,
// the external 68K bus master pins and the arbiter.
interface m68k_bus_arbiter_if;
  logic       op_req;
  logic       cyc_idle;
  logic       br_n;
  logic       bgack_n;
  logic       bg_n;
  logic       pi_go;
  logic       bus_release;
  logic [1:0] owner;

  // Arbiter side: samples requests and cycle status, drives grant and release.
  modport master (
    input  op_req,
    input  cyc_idle,
    input  br_n,
    input  bgack_n,
    output bg_n,
    output pi_go,
    output bus_release,
    output owner
  );

  // Environment side: bus state machine and external master pins.
  modport slave (
    output op_req,
    output cyc_idle,
    output br_n,
    output bgack_n,
    input  bg_n,
    input  pi_go,
    input  bus_release,
    input  owner
  );
endinterface

// File: rtl/m68k_bus_arbiter.sv
// 68K bus arbiter: shares the bus between the Pi-side bus state machine and
// an external bus master using the BR/BG/BGACK handshake. After the external
// master gives the bus back, the Pi is owed one cycle before the next grant.
module m68k_bus_arbiter (
  input  logic                c7m,
  input  logic                op_reqrst,
  m68k_bus_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    OWN     = 2'b00,
    GRANT   = 2'b01,
    EXT     = 2'b10,
    RECLAIM = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic       br_meta_q, br_meta_d;
  logic       br_s_q, br_s_d;
  logic       bgack_meta_q, bgack_meta_d;
  logic       bgack_s_q, bgack_s_d;
  logic [5:0] timer_q, timer_d;
  logic       slot_owed_q, slot_owed_d;
  logic       cyc_idle_q, cyc_idle_d;
  logic       bg_n_q, bg_n_d;
  logic       bus_release_q, bus_release_d;

  logic       grantable;
  logic       pi_go_c;
  logic       pi_start;

  // Synchroniser chains for the asynchronous master pins, plus the previous
  // cyc_idle sample used to spot the start of a Pi cycle.
  always_comb begin
    br_meta_d    = bus.br_n;
    br_s_d       = br_meta_q;
    bgack_meta_d = bus.bgack_n;
    bgack_s_d    = bgack_meta_q;
    cyc_idle_d   = bus.cyc_idle;
  end

  // The Pi may only be skipped when it is not owed a slot or has nothing to do.
  assign grantable = !slot_owed_q || !bus.op_req;

  // Next-state, timer, owed-slot and output decode.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    slot_owed_d = slot_owed_q;
    pi_go_c     = 1'b0;
    pi_start    = 1'b0;

    case (state_q)
      OWN: begin
        // Hold the Pi in S1 while a grant or takeover is pending so no new
        // cycle starts under the external master.
        pi_go_c  = !((!br_s_q && grantable) || !bgack_s_q);
        pi_start = pi_go_c && bus.op_req && cyc_idle_q && !bus.cyc_idle;
        if (pi_start) begin
          slot_owed_d = 1'b0;
        end
        // Ownership only changes between cycles; an unsolicited BGACK beats BR.
        if (!bgack_s_q && bus.cyc_idle) begin
          state_d = EXT;
        end else if (!br_s_q && grantable && bus.cyc_idle) begin
          state_d = GRANT;
          timer_d = '0;
        end
      end

      GRANT: begin
        timer_d = timer_q + 6'd1;
        // Give up the grant if the master withdraws BR or never acknowledges.
        if (!bgack_s_q) begin
          state_d = EXT;
        end else if (br_s_q) begin
          state_d = OWN;
        end else if (timer_q == 6'd63) begin
          state_d = OWN;
        end
      end

      EXT: begin
        if (bgack_s_q) begin
          state_d = RECLAIM;
        end
      end

      RECLAIM: begin
        // One turnaround clock with drivers still off, then the Pi is owed a slot.
        state_d     = OWN;
        slot_owed_d = 1'b1;
      end

      default: begin
        state_d = OWN;
      end
    endcase

    // Outputs registered from the next state so they change cleanly with owner.
    bg_n_d        = (state_d != GRANT);
    bus_release_d = (state_d == EXT) || (state_d == RECLAIM);
  end

  // All state, asynchronously forced to the Pi-owns-bus condition on reset.
  always_ff @(posedge c7m or posedge op_reqrst) begin
    if (op_reqrst) begin
      state_q       <= OWN;
      br_meta_q     <= 1'b1;
      br_s_q        <= 1'b1;
      bgack_meta_q  <= 1'b1;
      bgack_s_q     <= 1'b1;
      timer_q       <= '0;
      slot_owed_q   <= 1'b0;
      cyc_idle_q    <= 1'b1;
      bg_n_q        <= 1'b1;
      bus_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      br_meta_q     <= br_meta_d;
      br_s_q        <= br_s_d;
      bgack_meta_q  <= bgack_meta_d;
      bgack_s_q     <= bgack_s_d;
      timer_q       <= timer_d;
      slot_owed_q   <= slot_owed_d;
      cyc_idle_q    <= cyc_idle_d;
      bg_n_q        <= bg_n_d;
      bus_release_q <= bus_release_d;
    end
  end

  assign bus.owner       = state_q;
  assign bus.bg_n        = bg_n_q;
  assign bus.bus_release = bus_release_q;
  assign bus.pi_go       = pi_go_c;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed bench for m68k_bus_arbiter. Observed vector is
// {owner[1:0], bg_n, bus_release, pi_go}.
module tb_m68k_bus_arbiter;

  logic c7m;
  logic op_reqrst;
  int   checks;
  int   errors;

  m68k_bus_arbiter_if bus ();

  m68k_bus_arbiter dut (
    .c7m       (c7m),
    .op_reqrst (op_reqrst),
    .bus       (bus)
  );

  initial c7m = 1'b0;
  always #5 c7m = ~c7m;

  function automatic logic [4:0] obs();
    return {bus.owner, bus.bg_n, bus.bus_release, bus.pi_go};
  endfunction

  // Advance one clock; inputs change and outputs are sampled 2 time units after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge c7m);
      #2;
    end
  endtask

  task automatic test_reset();
    op_reqrst    = 1'b1;
    bus.op_req   = 1'b0;
    bus.cyc_idle = 1'b1;
    bus.br_n     = 1'b1;
    bus.bgack_n  = 1'b1;
    #1;
    checks++;
    if (obs() !== 5'b00101) begin
      errors++; $display("FAIL reset_async got %b exp %b", obs(), 5'b00101);
    end
    step(2);
    checks++;
    if (obs() !== 5'b00101) begin
      errors++; $display("FAIL reset_held got %b exp %b", obs(), 5'b00101);
    end
    op_reqrst = 1'b0;
    step(1);
    checks++;
    if (obs() !== 5'b00101) begin
      errors++; $display("FAIL reset_idle got %b exp %b", obs(), 5'b00101);
    end
  endtask

  task automatic test_grant_cycle();
    bus.br_n = 1'b0;
    step(1);
    checks++;
    if (obs() !== 5'b00101) begin
      errors++; $display("FAIL grant_edge1 got %b exp %b", obs(), 5'b00101);
    end
    step(1);
    checks++;
    if (obs() !== 5'b00100) begin
      errors++; $display("FAIL grant_edge2 got %b exp %b", obs(), 5'b00100);
    end
    step(1);
    checks++;
    if (obs() !== 5'b01000) begin
      errors++; $display("FAIL grant_edge3 got %b exp %b", obs(), 5'b01000);
    end
    bus.bgack_n = 1'b0;
    bus.br_n    = 1'b1;
    step(2);
    checks++;
    if (obs() !== 5'b01000) begin
      errors++; $display("FAIL grant_wait_bgack got %b exp %b", obs(), 5'b01000);
    end
    step(1);
    checks++;
    if (obs() !== 5'b10110) begin
      errors++; $display("FAIL ext_entry got %b exp %b", obs(), 5'b10110);
    end
    bus.bgack_n = 1'b1;
    step(2);
    checks++;
    if (obs() !== 5'b10110) begin
      errors++; $display("FAIL ext_hold got %b exp %b", obs(), 5'b10110);
    end
    step(1);
    checks++;
    if (obs() !== 5'b11110) begin
      errors++; $display("FAIL reclaim got %b exp %b", obs(), 5'b11110);
    end
    step(1);
    checks++;
    if (obs() !== 5'b00101) begin
      errors++; $display("FAIL reclaim_to_own got %b exp %b", obs(), 5'b00101);
    end
  endtask

  task automatic test_slot_owed();
    bus.op_req = 1'b1;
    bus.br_n   = 1'b0;
    step(3);
    checks++;
    if (obs() !== 5'b00101) begin
      errors++; $display("FAIL owed_pi_wins got %b exp %b", obs(), 5'b00101);
    end
    bus.cyc_idle = 1'b0;
    step(1);
    checks++;
    if (obs() !== 5'b00100) begin
      errors++; $display("FAIL owed_cleared got %b exp %b", obs(), 5'b00100);
    end
    step(2);
    bus.op_req = 1'b0;
    step(1);
    checks++;
    if (obs() !== 5'b00100) begin
      errors++; $display("FAIL owed_cycle_busy got %b exp %b", obs(), 5'b00100);
    end
    bus.cyc_idle = 1'b1;
    step(1);
    checks++;
    if (obs() !== 5'b01000) begin
      errors++; $display("FAIL owed_then_grant got %b exp %b", obs(), 5'b01000);
    end
    bus.br_n = 1'b1;
    step(3);
    checks++;
    if (obs() !== 5'b00101) begin
      errors++; $display("FAIL owed_release got %b exp %b", obs(), 5'b00101);
    end
  endtask

  task automatic test_cycle_in_progress();
    bus.cyc_idle = 1'b0;
    bus.br_n     = 1'b0;
    step(4);
    checks++;
    if (obs() !== 5'b00100) begin
      errors++; $display("FAIL busy_no_grant got %b exp %b", obs(), 5'b00100);
    end
    bus.cyc_idle = 1'b1;
    step(1);
    checks++;
    if (obs() !== 5'b01000) begin
      errors++; $display("FAIL busy_then_grant got %b exp %b", obs(), 5'b01000);
    end
    bus.br_n = 1'b1;
    step(3);
    checks++;
    if (obs() !== 5'b00101) begin
      errors++; $display("FAIL busy_release got %b exp %b", obs(), 5'b00101);
    end
  endtask

  task automatic test_grant_timeout();
    int n;
    bus.br_n = 1'b0;
    step(3);
    checks++;
    if (obs() !== 5'b01000) begin
      errors++; $display("FAIL timeout_entry got %b exp %b", obs(), 5'b01000);
    end
    n = 0;
    while (bus.owner == 2'b01 && n < 100) begin
      step(1);
      n++;
    end
    checks++;
    if (n !== 64) begin
      errors++; $display("FAIL timeout_cycles got %0d exp %0d", n, 64);
    end
    checks++;
    if (obs() !== 5'b00100) begin
      errors++; $display("FAIL timeout_own got %b exp %b", obs(), 5'b00100);
    end
    step(1);
    checks++;
    if (obs() !== 5'b01000) begin
      errors++; $display("FAIL timeout_regrant got %b exp %b", obs(), 5'b01000);
    end
    bus.br_n = 1'b1;
    step(2);
    checks++;
    if (obs() !== 5'b01000) begin
      errors++; $display("FAIL withdraw_sync got %b exp %b", obs(), 5'b01000);
    end
    step(1);
    checks++;
    if (obs() !== 5'b00101) begin
      errors++; $display("FAIL withdraw_own got %b exp %b", obs(), 5'b00101);
    end
  endtask

  task automatic test_unsolicited_ext();
    bus.cyc_idle = 1'b0;
    bus.br_n     = 1'b0;
    bus.bgack_n  = 1'b0;
    step(3);
    checks++;
    if (obs() !== 5'b00100) begin
      errors++; $display("FAIL takeover_busy got %b exp %b", obs(), 5'b00100);
    end
    bus.cyc_idle = 1'b1;
    step(1);
    checks++;
    if (obs() !== 5'b10110) begin
      errors++; $display("FAIL takeover_priority got %b exp %b", obs(), 5'b10110);
    end
    bus.br_n = 1'b1;
    step(1);
    checks++;
    if (obs() !== 5'b10110) begin
      errors++; $display("FAIL takeover_hold got %b exp %b", obs(), 5'b10110);
    end
  endtask

  task automatic test_reset_in_ext();
    #1;
    op_reqrst = 1'b1;
    #1;
    checks++;
    if (obs() !== 5'b00101) begin
      errors++; $display("FAIL ext_reset_async got %b exp %b", obs(), 5'b00101);
    end
    bus.bgack_n = 1'b1;
    bus.br_n    = 1'b0;
    step(1);
    checks++;
    if (obs() !== 5'b00101) begin
      errors++; $display("FAIL ext_reset_held got %b exp %b", obs(), 5'b00101);
    end
    op_reqrst = 1'b0;
    step(2);
    checks++;
    if (obs() !== 5'b00100) begin
      errors++; $display("FAIL post_reset_edge2 got %b exp %b", obs(), 5'b00100);
    end
    step(1);
    checks++;
    if (obs() !== 5'b01000) begin
      errors++; $display("FAIL post_reset_edge3 got %b exp %b", obs(), 5'b01000);
    end
    bus.br_n = 1'b1;
    step(3);
    checks++;
    if (obs() !== 5'b00101) begin
      errors++; $display("FAIL post_reset_release got %b exp %b", obs(), 5'b00101);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_grant_cycle();
    test_slot_owed();
    test_cycle_in_progress();
    test_grant_timeout();
    test_unsolicited_ext();
    test_reset_in_ext();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m68k_bus_arbiter.md
M68K_BUS_ARBITER -- requirements
Module: m68k_bus_arbiter

Interface
REQ-001 c7m  in  1  68K bus clock; all state, counter and synchroniser updates on its rising edge.
REQ-002 op_reqrst  in  1  reset, asynchronous, active-high.
REQ-003 op_req  in  1  Pi transaction pending (high from REG_ADDR_HI write until cycle reaches S4).
REQ-004 cyc_idle  in  1  bus state machine in S0.
REQ-005 br_n  in  1  external master bus request, asynchronous, active-low.
REQ-006 bgack_n  in  1  external master grant acknowledge, asynchronous, active-low.
REQ-007 bg_n  out  1  bus grant to external master, active-low, registered.
REQ-008 pi_go  out  1  permits the bus state machine to leave S1 (ANDed with op_req at the S2 set term).
REQ-009 bus_release  out  1  high: Pi-side AS/UDS/LDS/RW, address and data latch drivers SHALL be tri-stated.
REQ-010 owner  out  2  current state code (OWN=00, GRANT=01, EXT=10, RECLAIM=11).

Function
REQ-011 br_n and bgack_n SHALL each pass a 2-FF synchroniser (br_s, bgack_s); no logic SHALL use the raw pins.
REQ-012 The block SHALL be a 4-state FSM OWN/GRANT/EXT/RECLAIM, plus a 6-bit grant timer and a 1-bit slot_owed flag.
REQ-013 grantable = (slot_owed==0) OR (op_req==0).
REQ-014 OWN: pi_go SHALL be 1 unless (br_s==0 AND grantable) OR bgack_s==0; bus_release=0; bg_n=1.
REQ-015 OWN->GRANT when br_s==0 AND grantable AND cyc_idle==1; timer SHALL load 0.
REQ-016 OWN->EXT when bgack_s==0 AND cyc_idle==1 (master takes the bus unsolicited); this SHALL take priority over REQ-015.
REQ-017 br_s==0 and cyc_idle==0: the FSM SHALL stay in OWN until the current cycle returns to S0; a cycle in progress SHALL never be cut.
REQ-018 GRANT: bg_n=0, pi_go=0, bus_release=0, and the timer SHALL increment each clock.
REQ-019 GRANT->EXT when bgack_s==0.
REQ-020 GRANT->OWN when br_s==1 AND bgack_s==1 (request withdrawn) or when the timer reaches 63 with bgack_s==1; bg_n SHALL return to 1 on that edge.
REQ-021 EXT: bg_n=1, pi_go=0, bus_release=1; EXT->RECLAIM when bgack_s==1.
REQ-022 RECLAIM: bus_release=1, pi_go=0 for exactly one clock of bus turnaround, then ->OWN with slot_owed set to 1.
REQ-023 slot_owed SHALL clear on the edge where owner==OWN, pi_go==1, op_req==1 and cyc_idle transitions 1->0 (Pi cycle started).
REQ-024 Simultaneous br_s==0 and op_req==1 in OWN with cyc_idle==1: the grant SHALL win if slot_owed==0; the Pi cycle SHALL win if slot_owed==1.
REQ-025 Latency: br_n falling with cyc_idle==1 and grantable SHALL produce bg_n==0 after the 3rd rising edge (2 sync + 1 FSM).
REQ-026 owner, bg_n and bus_release SHALL be glitch-free registered outputs; pi_go may be combinational from registered signals only.

Reset
REQ-027 op_reqrst high SHALL immediately force owner=OWN, bg_n=1, bus_release=0, pi_go=1, timer=0, slot_owed=0, and both synchronisers to 1, including mid-GRANT or mid-EXT.
REQ-028 After op_reqrst is released, the first grant SHALL require the full REQ-025 latency.

Verification
REQ-029 Idle bus, op_req=0, br_n low at t0 -> bg_n low after the 3rd edge; bgack_n low -> EXT, bus_release=1, bg_n=1; bgack_n high -> RECLAIM for 1 clock, then OWN, slot_owed=1.
REQ-030 Pi cycle in progress (cyc_idle=0), br_n low -> owner stays 00, bg_n=1 until cyc_idle=1, then GRANT 1 edge later.
REQ-031 slot_owed=1, op_req=1, br_n held low -> pi_go=1, Pi cycle starts, slot_owed clears, then GRANT once cyc_idle returns to 1.
REQ-032 GRANT with bgack_n never asserted and br_n held low -> return to OWN at timer=63, bg_n=1; br_n released early -> OWN on the next edge after br_s=1.
REQ-033 op_reqrst pulsed while in EXT -> owner=00, bus_release=0, bg_n=1 asynchronously, before the next c7m edge.
